// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Fixed 33-cycle latency: 32 shift-add / restoring-divide iterations plus one sign-fix/writeback cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem, div0;
  logic [WIDTH-1:0]   mag_a, mag_b, rs_raw;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic               busy_d, done_d;

  // operand conditioning at start
  logic             sgn_op;
  logic [WIDTH-1:0] abs_rs, abs_rt;
  assign sgn_op = ~op_i[0];
  assign abs_rs = (sgn_op && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
  assign abs_rt = (sgn_op && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;

  // multiply step: conditional add into upper half, then shift the whole accumulator right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // divide step: dividend bits shift out of acc's low half into rem, quotient bits shift in
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  assign div_diff = {rem, acc[WIDTH-1]} - {2'b0, mag_b};
  assign div_ok   = ~div_diff[WIDTH+1];

  // writeback values
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;
  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = ITER;
      ITER:    if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_nx != IDLE);
    done_d = (state == FIX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      rs_raw  <= '0;
      acc     <= '0;
      rem     <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      busy_o <= busy_d;
      done_o <= done_d;
      case (state)
        IDLE: begin
          if (start_i) begin
            cnt     <= '0;
            is_div  <= op_i[1];
            neg_res <= sgn_op & (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
            neg_rem <= sgn_op & rs_data_i[WIDTH-1];
            div0    <= (rt_data_i == '0);
            mag_a   <= abs_rs;
            mag_b   <= abs_rt;
            rs_raw  <= rs_data_i;
            acc     <= op_i[1] ? {{WIDTH{1'b0}}, abs_rs} : {{WIDTH{1'b0}}, abs_rt};
            rem     <= '0;
          end else begin
            // start wins over a simultaneous MT write
            if (mthi_i) hi_o <= wdata_i;
            if (mtlo_i) lo_o <= wdata_i;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ok};
            rem <= div_ok ? div_diff[WIDTH:0] : {rem[WIDTH-1:0], acc[WIDTH-1]};
          end else begin
            acc <= mul_nx;
          end
        end
        FIX: begin
          if (!is_div) begin
            hi_o <= prod[2*WIDTH-1:WIDTH];
            lo_o <= prod[WIDTH-1:0];
          end else if (div0) begin
            hi_o <= rs_raw;
            lo_o <= '1;
          end else begin
            hi_o <= rmd;
            lo_o <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
